// File: rtl/fp_mul_shift_add.sv
// Sequential single-precision multiplier: special operands resolve at acceptance,
// ordinary operands take 24 shift-add iterations, one normalize cycle, then a done pulse.
module fp_mul_shift_add (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_p,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t             r_state;
    state_t             w_state_next;

    logic [23:0]        r_ma;
    logic [23:0]        r_mb;
    logic [47:0]        r_acc;
    logic [4:0]         r_cnt;
    logic signed [9:0]  r_e;
    logic               r_sign;
    logic [31:0]        r_p;

    logic [31:0]        w_op [2];
    logic [1:0]         w_zero;
    logic [1:0]         w_inf;
    logic [1:0]         w_nan;
    logic               w_sign;
    logic               w_special;
    logic [31:0]        w_special_p;
    logic signed [9:0]  w_e_init;
    logic signed [9:0]  w_e_norm;
    logic [22:0]        w_frac;
    logic [31:0]        w_norm_p;

    assign w_op[0] = i_a;
    assign w_op[1] = i_b;

    // Denormals (exponent 0, nonzero fraction) are flushed, so exponent==0 alone means Zero.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cls
            assign w_zero[gi] = (w_op[gi][30:23] == 8'h00);
            assign w_inf[gi]  = (w_op[gi][30:23] == 8'hFF) && (w_op[gi][22:0] == 23'h0);
            assign w_nan[gi]  = (w_op[gi][30:23] == 8'hFF) && (w_op[gi][22:0] != 23'h0);
        end
    endgenerate

    assign w_sign    = i_a[31] ^ i_b[31];
    assign w_special = (|w_zero) | (|w_inf) | (|w_nan);
    assign w_e_init  = $signed({2'b00, i_a[30:23]}) + $signed({2'b00, i_b[30:23]}) - 10'sd127;

    always_comb begin
        w_special_p = {w_sign, 31'h0};
        if (|w_nan) begin
            w_special_p = QNAN;
        end else if ((w_inf[0] && w_zero[1]) || (w_inf[1] && w_zero[0])) begin
            w_special_p = QNAN;
        end else if (|w_inf) begin
            w_special_p = {w_sign, 8'hFF, 23'h0};
        end
    end

    // Product of two [1,2) mantissas lies in [1,4): bit 47 selects the normalization shift.
    always_comb begin
        w_e_norm = r_e;
        w_frac   = r_acc[45:23];
        if (r_acc[47]) begin
            w_e_norm = r_e + 10'sd1;
            w_frac   = r_acc[46:24];
        end
        if (w_e_norm >= 10'sd255) begin
            w_norm_p = {r_sign, 8'hFF, 23'h0};
        end else if (w_e_norm <= 10'sd0) begin
            w_norm_p = {r_sign, 31'h0};
        end else begin
            w_norm_p = {r_sign, w_e_norm[7:0], w_frac};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_state_next = w_special ? S_DONE : S_MUL;
            S_MUL:  if (r_cnt == 5'd23) w_state_next = S_NORM;
            S_NORM: w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ma   <= 24'h0;
            r_mb   <= 24'h0;
            r_acc  <= 48'h0;
            r_cnt  <= 5'h0;
            r_e    <= 10'sd0;
            r_sign <= 1'b0;
            r_p    <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (w_special) begin
                            r_p <= w_special_p;
                        end else begin
                            r_ma   <= {1'b1, i_a[22:0]};
                            r_mb   <= {1'b1, i_b[22:0]};
                            r_e    <= w_e_init;
                            r_sign <= w_sign;
                            r_acc  <= 48'h0;
                            r_cnt  <= 5'h0;
                        end
                    end
                end
                S_MUL: begin
                    if (r_mb[r_cnt]) begin
                        r_acc <= r_acc + (48'(r_ma) << r_cnt);
                    end
                    if (r_cnt != 5'd23) begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_NORM: begin
                    r_p <= w_norm_p;
                    r_e <= w_e_norm;
                end
                default: ;
            endcase
        end
    end

    assign o_p    = r_p;
    assign o_busy = (r_state == S_MUL) || (r_state == S_NORM);
    assign o_done = (r_state == S_DONE);

endmodule

// File: tb/tb_fp_mul_shift_add.sv
// Bench for fp_mul_shift_add: directed vectors, randomized operands against an
// arithmetic reference model, start-during-MUL and mid-operation reset scenarios.
module tb_fp_mul_shift_add;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [31:0] o_p;
    logic        o_busy;
    logic        o_done;

    int n_checks;
    int n_fail;

    fp_mul_shift_add dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_p     (o_p),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic bit ref_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
               (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
    endfunction

    // Plain-arithmetic model: full 48-bit product in one multiply, then truncate.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int          ea, eb, e;
        longint      fa, fb, prod, frac;
        bit          s, za, zb, ia, ib, na, nb;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = longint'(a[22:0]);
        fb = longint'(b[22:0]);
        s  = a[31] ^ b[31];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (fa == 0);
        ib = (eb == 255) && (fb == 0);
        na = (ea == 255) && (fa != 0);
        nb = (eb == 255) && (fb != 0);
        if (na || nb) return 32'h7FC00000;
        if ((ia && zb) || (ib && za)) return 32'h7FC00000;
        if (ia || ib) return {s, 8'hFF, 23'h0};
        if (za || zb) return {s, 31'h0};
        prod = (fa + 64'h800000) * (fb + 64'h800000);
        e    = ea + eb - 127;
        if (prod >= (64'd1 << 47)) begin
            e    = e + 1;
            frac = (prod >> 24) & 64'h7FFFFF;
        end else begin
            frac = (prod >> 23) & 64'h7FFFFF;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), 23'(frac)};
    endfunction

    // One transaction: checks busy after acceptance, done latency, result, pulse width, hold.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_p);
        bit special;
        int k;
        special = ref_special(a, b);
        @(negedge clk);
        i_start = 1'b1;
        i_a     = a;
        i_b     = b;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        check_eq({tag, "_busy"}, 32'(o_busy), special ? 32'd0 : 32'd1);
        k = 0;
        while (!o_done && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq({tag, "_lat"}, 32'(k), special ? 32'd0 : 32'd25);
        check_eq({tag, "_p"}, o_p, exp_p);
        @(posedge clk);
        #1;
        check_eq({tag, "_pulse"}, 32'(o_done), 32'd0);
        check_eq({tag, "_hold"}, o_p, exp_p);
        $display("op %s A=%h B=%h P=%h exp=%h lat=%0d", tag, a, b, o_p, exp_p, k);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        int          sel;
        v   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel == 0) v[30:23] = 8'h00;
        else if (sel == 1) v[30:23] = 8'hFF;
        else if (sel == 2) v[22:0] = ($urandom_range(0, 1) == 0) ? 23'h0 : v[22:0];
        else if (sel < 7) v[30:23] = 8'($urandom_range(100, 155));
        return v;
    endfunction

    initial begin
        int          k;
        int          done_seen;
        logic [31:0] ra, rb;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        i_start  = 1'b0;
        i_a      = 32'h0;
        i_b      = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_p", o_p, 32'h0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_done", 32'(o_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul2x3",   32'h40000000, 32'h40400000, 32'h40C00000);
        run_op("carry",    32'h3FC00000, 32'h3FC00000, 32'h40100000);
        run_op("sign",     32'hBF800000, 32'h3F000000, 32'hBF000000);
        run_op("infxzero", 32'h7F800000, 32'h00000000, 32'h7FC00000);
        run_op("nan",      32'h7FC00001, 32'h3F800000, 32'h7FC00000);
        run_op("ninf",     32'hFF800000, 32'h40000000, 32'hFF800000);
        run_op("nzero",    32'h80000000, 32'h40000000, 32'h80000000);
        run_op("ovf",      32'h7F000000, 32'h7F000000, 32'h7F800000);
        run_op("unf",      32'h00800000, 32'h00800000, 32'h00000000);
        run_op("denorm",   32'h00000001, 32'h3F800000, 32'h00000000);

        for (int i = 0; i < 40; i++) begin
            ra = rand_operand();
            rb = rand_operand();
            run_op($sformatf("rnd%0d", i), ra, rb, ref_mul(ra, rb));
        end

        // Second start during MUL must be ignored.
        @(negedge clk);
        i_start = 1'b1;
        i_a     = 32'h40000000;
        i_b     = 32'h40400000;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        i_start = 1'b1;
        i_a     = 32'h3FC00000;
        i_b     = 32'hC0800000;
        @(negedge clk);
        i_start = 1'b0;
        k = 6;
        #1;
        while (!o_done && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("ign_lat", 32'(k), 32'd25);
        check_eq("ign_p", o_p, 32'h40C00000);
        @(posedge clk);
        #1;
        check_eq("ign_idle", 32'(o_busy), 32'd0);
        $display("op ignore_start P=%h lat=%0d", o_p, k);

        // Reset at MUL iteration 10 aborts with no done pulse.
        @(negedge clk);
        i_start = 1'b1;
        i_a     = 32'h3FC00000;
        i_b     = 32'h3FC00000;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort_p", o_p, 32'h0);
        check_eq("abort_busy", 32'(o_busy), 32'd0);
        check_eq("abort_done", 32'(o_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (o_done) done_seen++;
        end
        check_eq("abort_nodone", 32'(done_seen), 32'd0);
        $display("op abort_reset P=%h done_seen=%0d", o_p, done_seen);

        run_op("after_rst", 32'h3FC00000, 32'h3FC00000, 32'h40100000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_mul_shift_add.md
# fp_mul_shift_add

Sequential IEEE-754 single-precision multiplier core that consumes the special-case flags (Inf / NaN / Zero) produced per operand by the operand classifier and, for ordinary operands, forms the 24×24 mantissa product by iterative shift-add, one partial product per clock. It sits directly downstream of the two operand classifiers in the MUL/SHIFT_ADD datapath. It registers a packed 32-bit result with a single-cycle done pulse.

## Interface
- No parameters. Widths are fixed: 32-bit operands, 24-bit mantissas, 48-bit product, 10-bit signed working exponent.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  32  operand A (IEEE-754 single). Sampled on the accepting edge.
- B  input  32  operand B. Sampled on the accepting edge.
- P  output  32  result, registered; held until the next result write.
- busy  output  1  high in MUL and NORM.
- done  output  1  one-cycle pulse; P is valid while done is high and afterwards.

## Operation
- Operand classification uses the classifier's rules, applied to A and B at the accepting edge:
  - Zero: bits[30:0]==0.
  - Inf: exponent==8'hFF and fraction==0.
  - NaN: exponent==8'hFF and fraction!=0.
  - Denormal (exponent==0, fraction!=0): treated as Zero (flush).
- Result sign: s = A[31]^B[31].
- Special-case priority, evaluated at the accepting edge:
  1. Either operand NaN → P=32'h7FC00000.
  2. Inf×Zero in either order → P=32'h7FC00000.
  3. Either operand Inf → P={s,8'hFF,23'h0}.
  4. Either operand Zero → P={s,31'h0}.
  5. Otherwise → normal path.
- Normal path:
  - Latch mA={1,A[22:0]}, mB={1,B[22:0]}.
  - Working exponent e = A[30:23] + B[30:23] − 127, 10-bit signed.
  - Clear the 48-bit accumulator and the 5-bit iteration counter.
- MUL iteration i, for i = 0..23, one per clock: if mB[i], acc += mA<<i. No other arithmetic is performed during MUL.
- NORM:
  - If acc[47]: frac=acc[46:24], e=e+1.
  - Else: frac=acc[45:23].
  - Rounding is truncation (round toward zero).
  - If e ≥ 255 → P={s,8'hFF,23'h0} (overflow to Inf).
  - If e ≤ 0 → P={s,31'h0} (underflow to zero, no denormals).
  - Otherwise → P={s,e[7:0],frac}.
- FSM states and transitions:
  - IDLE: start & special → DONE; start & normal → MUL; otherwise stay.
  - MUL: counter==23 → NORM; otherwise increment the counter.
  - NORM → DONE.
  - DONE → IDLE, unconditionally.
- start is ignored in MUL, NORM and DONE. Operands are not re-sampled and no request is queued.
- Reset values: state=IDLE, P=32'h0, done=0, busy=0, accumulator=0, counter=0, e=0.
- Reset asserted mid-operation aborts immediately. No done pulse follows.

## Timing
- Edge numbering: edge 0 is the rising edge that samples start=1 in IDLE.
- Special case:
  - P is written at edge 0.
  - done is high for the cycle following edge 0.
  - Back in IDLE after edge 1.
  - busy stays 0 throughout.
- Normal case:
  - MUL iterations occur at edges 1..24.
  - NORM writes P at edge 25.
  - done is high for the cycle after edge 25.
  - IDLE after edge 26.
  - busy is high from after edge 0 through edge 25.
- Throughput: a new start is accepted no earlier than edge 2 (special case) or edge 27 (normal case).
- done is never high for more than one consecutive cycle.
- P changes only on result-write edges and on reset.

## Test plan
- Basic normal product: A=32'h40000000 (2.0), B=32'h40400000 (3.0) → P=32'h40C00000. done is exactly one cycle, 26 clocks after start.
- Normalize carry: A=B=32'h3FC00000 (1.5) → P=32'h40100000 (2.25). Sign handling: A=32'hBF800000, B=32'h3F000000 → P=32'hBF000000.
- Special cases, each with done one cycle after start and busy=0:
  - A=32'h7F800000, B=32'h00000000 → P=32'h7FC00000.
  - A=32'h7FC00001, B=32'h3F800000 → P=32'h7FC00000.
  - A=32'hFF800000, B=32'h40000000 → P=32'hFF800000.
  - A=32'h80000000, B=32'h40000000 → P=32'h80000000.
- Range limits:
  - A=B=32'h7F000000 → P=32'h7F800000 (overflow).
  - A=B=32'h00800000 → P=32'h00000000 (underflow).
  - A=32'h00000001 (denormal), B=32'h3F800000 → P=32'h00000000.
- Robustness: pulse start again during MUL with different operands → ignored, first result unchanged. Assert rst at MUL iteration 10 → outputs return to reset values immediately, no done pulse. A fresh start then completes correctly.
